// File: rtl/m_sequence_rx.sv
// m_sequence_rx: m-sequence frame receiver that recovers the transmitter's shift code and counts chip errors.
// Latency: code_valid_o pulses k+2 edges after the edge accepting chip N (k = code), or 2 edges for an all-zero capture.
// Backpressure: none; the receiver never stalls chips. Chips arriving while busy in SEARCH/DONE are dropped, so the sender waits for busy_o=0.
//
// Ports:
//   clkin        - single clock, rising edge
//   rst          - synchronous active-high reset
//   chip_i       - received chip, sampled when chip_valid_i=1
//   chip_valid_i - one-cycle qualifier per chip; gaps allowed
//   sof_i        - marks chip 1 of a frame (only with chip_valid_i=1)
//   code_o       - recovered shift code, held until the next code_valid_o
//   code_valid_o - one-cycle pulse; code_o/err_cnt_o/err_o valid in that cycle
//   err_cnt_o    - chip mismatches counted in the last frame, held
//   err_o        - frame error flag (too many mismatches or all-zero phase), held
//   busy_o       - high while a frame is being received or decoded
module m_sequence_rx #(
    parameter int                N          = 63,
    parameter int                LENGTH     = $clog2(N),
    parameter logic [LENGTH-1:0] POLYNOME   = 6'b100111,
    parameter logic [LENGTH-1:0] BASE_PHASE = 6'b101010,
    parameter int                MAX_ERR    = 4
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic                   chip_i,
    input  logic                   chip_valid_i,
    input  logic                   sof_i,
    output logic [LENGTH-1:0]      code_o,
    output logic                   code_valid_o,
    output logic [$clog2(N+1)-1:0] err_cnt_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int CW = $clog2(N+1);

    // Compare values are taken against the count *before* the current chip
    // is added, so "cnt == X" means "this chip is chip X+1".
    localparam logic [CW-1:0]     CNT_FILL     = CW'(LENGTH - 1);
    localparam logic [CW-1:0]     CNT_PRE_LAST = CW'(N - 1);
    localparam logic [CW-1:0]     ERR_SAT      = '1;
    localparam logic [LENGTH-1:0] IDX_LAST     = LENGTH'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        TRACK  = 3'd2,
        SEARCH = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [LENGTH-1:0] w;            // chip window, w[0] = oldest chip
    logic [LENGTH-1:0] cap;          // transmitter initial phase
    logic [LENGTH-1:0] s;            // search LFSR
    logic [LENGTH-1:0] idx;          // number of steps s has taken from BASE_PHASE
    logic [CW-1:0]     cnt;          // chips accepted in the current frame
    logic [CW-1:0]     err_cnt;      // mismatches in the current frame
    logic              search_init;  // first SEARCH cycle loads s/idx

    logic [LENGTH-1:0] w_next;
    logic [LENGTH-1:0] s_next;
    logic              predicted;
    logic              mismatch;
    logic              cap_zero;
    logic              s_hit;
    logic              search_end;

    // Received window and search LFSR advance the same way as the transmitter:
    // the feedback bit enters at the MSB and the oldest bit leaves at bit 0.
    assign w_next     = {chip_i, w[LENGTH-1:1]};
    assign s_next     = {^(POLYNOME & s), s[LENGTH-1:1]};
    assign predicted  = ^(POLYNOME & w);
    assign mismatch   = (chip_i != predicted);
    assign cap_zero   = (cap == '0);
    assign s_hit      = (s == cap);
    // IDX_LAST without a hit cannot happen for a primitive polynomial; it is a
    // guard so a mismatched POLYNOME/BASE_PHASE cannot lock the block in SEARCH.
    assign search_end = cap_zero || s_hit || (idx == IDX_LAST);

    always_ff @(posedge clkin) begin
        if (rst) begin
            state        <= IDLE;
            w            <= '0;
            cap          <= '0;
            s            <= '0;
            idx          <= '0;
            cnt          <= '0;
            err_cnt      <= '0;
            search_init  <= 1'b0;
            code_o       <= '0;
            code_valid_o <= 1'b0;
            err_cnt_o    <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            code_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (chip_valid_i && sof_i) begin
                        w       <= w_next;
                        cnt     <= CW'(1);
                        err_cnt <= '0;
                        state   <= LOAD;
                        busy_o  <= 1'b1;
                    end
                end

                LOAD, TRACK: begin
                    if (chip_valid_i) begin
                        w <= w_next;
                        if (sof_i) begin
                            // A new start-of-frame abandons the current frame.
                            cnt     <= CW'(1);
                            err_cnt <= '0;
                            state   <= LOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (state == LOAD) begin
                                if (cnt == CNT_FILL) begin
                                    cap   <= w_next;
                                    state <= TRACK;
                                end
                            end else begin
                                if (mismatch && (err_cnt != ERR_SAT)) begin
                                    err_cnt <= err_cnt + 1'b1;
                                end
                                if (cnt == CNT_PRE_LAST) begin
                                    state       <= SEARCH;
                                    search_init <= 1'b1;
                                end
                            end
                        end
                    end
                end

                SEARCH: begin
                    if (search_init) begin
                        s           <= BASE_PHASE;
                        idx         <= '0;
                        search_init <= 1'b0;
                    end else if (search_end) begin
                        state        <= DONE;
                        code_valid_o <= 1'b1;
                        err_cnt_o    <= err_cnt;
                        code_o       <= (s_hit && !cap_zero) ? idx : '0;
                        err_o        <= cap_zero || !s_hit || (int'(err_cnt) > MAX_ERR);
                    end else begin
                        s   <= s_next;
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_sequence_rx.sv
// tb_m_sequence_rx: directed bench for m_sequence_rx with a transmitter model and hand-derived expected codes.
// Latency: measures edges from the edge accepting chip N to the code_valid_o pulse.
// Backpressure: the bench sends frames only while busy_o is low, except where it deliberately probes ignored chips.
module tb_m_sequence_rx;

    localparam logic [5:0] POLY = 6'b100111;
    localparam logic [5:0] BASE = 6'b101010;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       chip_i = 1'b0;
    logic       chip_valid_i = 1'b0;
    logic       sof_i = 1'b0;
    logic [5:0] code_o;
    logic       code_valid_o;
    logic [5:0] err_cnt_o;
    logic       err_o;
    logic       busy_o;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    m_sequence_rx dut (
        .clkin        (clkin),
        .rst          (rst),
        .chip_i       (chip_i),
        .chip_valid_i (chip_valid_i),
        .sof_i        (sof_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .err_cnt_o    (err_cnt_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) begin
        if (code_valid_o) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] tx_step(input logic [5:0] st);
        return {^(POLY & st), st[5:1]};
    endfunction

    // Inputs change #1 after a rising edge and are accepted at the next one.
    task automatic send_chip(input logic b, input logic sof);
        chip_i       = b;
        sof_i        = sof;
        chip_valid_i = 1'b1;
        @(posedge clkin);
        #1;
        chip_valid_i = 1'b0;
        sof_i        = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    // Transmitter model: start at BASE advanced 'code' steps, emit st[0] per chip.
    // flip = chip number to invert (0 = none); gaps inserts random idle cycles.
    task automatic send_frame(input int code, input int nchips, input int flip, input bit gaps);
        logic [5:0] st;
        logic       b;
        st = BASE;
        for (int i = 0; i < code; i++) st = tx_step(st);
        for (int c = 1; c <= nchips; c++) begin
            b = st[0];
            if (c == flip) b = ~b;
            send_chip(b, c == 1);
            st = tx_step(st);
            if (gaps && c < nchips) idle_cycles($urandom_range(0, 2));
        end
    endtask

    // Counts edges after the current one until code_valid_o is seen; bounded.
    task automatic wait_code(input string tag, output int edges);
        edges = 0;
        while (code_valid_o !== 1'b1 && edges < 300) begin
            @(posedge clkin);
            #1;
            edges++;
        end
        chk({tag, "_seen"}, int'(code_valid_o), 1);
    endtask

    initial begin
        int lat;
        int p0;

        // Reset state
        idle_cycles(3);
        chk("rst_code",  int'(code_o), 0);
        chk("rst_valid", int'(code_valid_o), 0);
        chk("rst_errcnt", int'(err_cnt_o), 0);
        chk("rst_err",   int'(err_o), 0);
        chk("rst_busy",  int'(busy_o), 0);
        rst = 1'b0;
        idle_cycles(1);

        // Chips without sof are ignored in IDLE
        for (int i = 0; i < 10; i++) send_chip(i[0], 1'b0);
        chk("nosof_busy", int'(busy_o), 0);

        // Clean code-0 frame: 2-edge latency
        send_frame(0, 63, 0, 1'b0);
        chk("c0_busy", int'(busy_o), 1);
        wait_code("c0", lat);
        chk("c0_lat",    lat, 2);
        chk("c0_code",   int'(code_o), 0);
        chk("c0_errcnt", int'(err_cnt_o), 0);
        chk("c0_err",    int'(err_o), 0);
        chk("c0_busy_done", int'(busy_o), 1);
        idle_cycles(1);
        chk("c0_valid_drop", int'(code_valid_o), 0);
        chk("c0_busy_idle", int'(busy_o), 0);
        chk("c0_code_held", int'(code_o), 0);

        // Clean code-62 frame with random gaps: 64-edge latency
        send_frame(62, 63, 0, 1'b1);
        wait_code("c62", lat);
        chk("c62_lat",  lat, 64);
        chk("c62_code", int'(code_o), 62);
        chk("c62_err",  int'(err_o), 0);
        idle_cycles(2);

        // Code 25, chip 30 inverted: mismatches at chips 30,31,34,35,36
        send_frame(25, 63, 30, 1'b0);
        wait_code("c25", lat);
        chk("c25_lat",    lat, 27);
        chk("c25_code",   int'(code_o), 25);
        chk("c25_errcnt", int'(err_cnt_o), 5);
        chk("c25_err",    int'(err_o), 1);
        idle_cycles(2);

        // All-zero frame: search bypassed, zero-state error
        send_chip(1'b0, 1'b1);
        for (int i = 2; i <= 63; i++) send_chip(1'b0, 1'b0);
        wait_code("zero", lat);
        chk("zero_lat",    lat, 2);
        chk("zero_code",   int'(code_o), 0);
        chk("zero_errcnt", int'(err_cnt_o), 0);
        chk("zero_err",    int'(err_o), 1);
        idle_cycles(2);

        // Reset after 20 chips, then clean code-7 frame
        p0 = pulses;
        send_frame(11, 20, 0, 1'b0);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        chk("rstmid_busy", int'(busy_o), 0);
        idle_cycles(5);
        chk("rstmid_pulses", pulses - p0, 0);
        send_frame(7, 63, 0, 1'b0);
        wait_code("c7", lat);
        chk("c7_lat",    lat, 9);
        chk("c7_code",   int'(code_o), 7);
        chk("c7_errcnt", int'(err_cnt_o), 0);
        chk("c7_err",    int'(err_o), 0);
        idle_cycles(2);

        // sof at chip 40 of a code-3 frame restarts as a code-9 frame
        p0 = pulses;
        send_frame(3, 39, 0, 1'b0);
        send_frame(9, 63, 0, 1'b0);
        wait_code("c9", lat);
        chk("c9_lat",    lat, 11);
        chk("c9_code",   int'(code_o), 9);
        chk("c9_errcnt", int'(err_cnt_o), 0);
        chk("c9_err",    int'(err_o), 0);
        idle_cycles(3);
        chk("c9_pulses", pulses - p0, 1);

        // Chips (including sof) during SEARCH are ignored
        p0 = pulses;
        send_frame(5, 63, 0, 1'b0);
        send_chip(1'b1, 1'b1);
        send_chip(1'b0, 1'b0);
        send_chip(1'b1, 1'b0);
        wait_code("c5", lat);
        chk("c5_code", int'(code_o), 5);
        chk("c5_err",  int'(err_o), 0);
        idle_cycles(4);
        chk("c5_busy_after", int'(busy_o), 0);
        chk("c5_pulses", pulses - p0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/m_sequence_rx.md
M_SEQUENCE_RX -- requirements
Module: m_sequence_rx

Interface
REQ-001 Parameter POLYNOME, default 6'b100111, feedback taps without leading "1"; SHALL match the transmitting generator.
REQ-002 Parameter N, default 63, chips per frame.
REQ-003 Parameter LENGTH, default $clog2(N), LFSR width.
REQ-004 Parameter BASE_PHASE, default 6'b101010, LFSR state corresponding to code 0.
REQ-005 Parameter MAX_ERR, default 4, largest chip-mismatch count still reported as error-free.
REQ-006 clkin  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 chip_i  in  1  received chip, sampled only when chip_valid_i=1.
REQ-009 chip_valid_i  in  1  one-cycle qualifier per chip; arbitrary gaps allowed.
REQ-010 sof_i  in  1  marks the chip as chip 1 of a frame; meaningful only with chip_valid_i=1.
REQ-011 code_o  out  LENGTH  recovered shift code, held until next code_valid_o.
REQ-012 code_valid_o  out  1  one-cycle pulse; code_o, err_cnt_o, err_o valid in that cycle.
REQ-013 err_cnt_o  out  $clog2(N+1)  chip mismatches counted in last frame, held.
REQ-014 err_o  out  1  frame error flag, held.
REQ-015 busy_o  out  1  high in LOAD, TRACK, SEARCH, DONE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, TRACK, SEARCH, DONE.
REQ-017 IDLE: chips with sof_i=0 ignored; chip with sof_i=1 -> LOAD, chip counted as chip 1, err counter cleared.
REQ-018 Window register w (LENGTH bits) SHALL shift on each accepted chip as w <= {chip_i, w[LENGTH-1:1]} (w[0] = oldest chip).
REQ-019 LOAD: after chip LENGTH accepted, w (= transmitter initial phase) SHALL be copied to capture register cap; go to TRACK.
REQ-020 TRACK: per accepted chip, predicted = ^(POLYNOME & w) before shift; chip_i != predicted increments err counter; w shifts in the received chip.
REQ-021 After chip N accepted, go to SEARCH; chips arriving in SEARCH/DONE SHALL be ignored, including sof_i.
REQ-022 sof_i=1 with chip_valid_i in LOAD or TRACK SHALL restart the frame: chip becomes chip 1, err counter cleared, state LOAD.
REQ-023 SEARCH: first cycle loads search LFSR s=BASE_PHASE, idx=0; each cycle, s==cap -> DONE with code=idx, else s <= {^(POLYNOME & s), s[LENGTH-1:1]}, idx+1.
REQ-024 cap all-zero SHALL bypass search: DONE with code=0 and zero-state error set.
REQ-025 Code value N (63) is never produced; BASE_PHASE decodes as 0.
REQ-026 Match at step k: code_valid_o SHALL pulse exactly k+2 clock edges after the edge accepting chip N; zero state: 2 edges.
REQ-027 DONE (one cycle): code_valid_o=1, code_o, err_cnt_o updated; err_o = (err count > MAX_ERR) or zero-state; next state IDLE.
REQ-028 err counter SHALL saturate at 2^$clog2(N+1)-1 (never wraps); max attainable N-LENGTH.
REQ-029 A chip with sof_i=1 arriving in the DONE->IDLE transition cycle is ignored; sender SHALL respect busy_o=0.

Reset
REQ-030 rst=1 at any edge: state IDLE, code_o=0, code_valid_o=0, err_cnt_o=0, err_o=0, busy_o=0, counters and w/cap/s cleared; partial frames discarded.
REQ-031 First frame after rst deasserts SHALL require sof_i.

Verification
REQ-032 Frame from BASE_PHASE (first chips 0,1,0,1,0,1), clean -> code_o=0, err_cnt_o=0, err_o=0, code_valid_o 2 edges after chip 63.
REQ-033 Clean frame for code 62 with random chip_valid_i gaps -> code_o=62, err_o=0, code_valid_o 64 edges after chip 63.
REQ-034 Code 25 frame, chip 30 inverted -> code_o=25, err_cnt_o=5 (chips 30,31,34,35,36), err_o=1 with MAX_ERR=4.
REQ-035 63 zero chips with sof -> code_o=0, err_cnt_o=0, err_o=1, code_valid_o 2 edges after chip 63.
REQ-036 rst after 20 chips of a frame -> no code_valid_o, busy_o=0 next cycle; following clean code-7 frame -> code_o=7, err_o=0.
REQ-037 sof_i reasserted at chip 40 of code-3 frame, then full clean code-9 frame -> single code_valid_o, code_o=9, err_cnt_o=0.
